// File: rtl/ram_arbiter.sv
// Two-port arbiter for a single-port, combinational-read RAM with registered read-back.
// Define RAM_ARB_FIXED_PRIO_EN to make port 0 win every tie instead of round robin.
module ram_arbiter #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned AW    = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_req0,
   input  logic             i_req1,
   input  logic             i_we0,
   input  logic             i_we1,
   input  logic [AW-1:0]    i_addr0,
   input  logic [AW-1:0]    i_addr1,
   input  logic [WIDTH-1:0] i_wdata0,
   input  logic [WIDTH-1:0] i_wdata1,
   output logic             o_ack0,
   output logic             o_ack1,
   output logic [WIDTH-1:0] o_rdata0,
   output logic [WIDTH-1:0] o_rdata1,
   output logic             o_gnt0,
   output logic             o_gnt1,
   output logic [WIDTH-1:0] o_ram_din,
   output logic [AW-1:0]    o_ram_addr,
   output logic             o_ram_we,
   input  logic [WIDTH-1:0] i_ram_dout
);

   typedef enum logic [1:0] {StIdle, StG0, StG1} state_e;

   state_e           r_state, w_state_d;
   logic             r_last, w_last_d;
   logic             r_ack0, r_ack1;
   logic [WIDTH-1:0] r_rdata0, r_rdata1;
   logic             w_elig0, w_elig1;

   // The port being served still holds req until it sees ack, so mask it for this edge.
   always_comb begin
      w_elig0   = i_req0 && (r_state != StG0);
      w_elig1   = i_req1 && (r_state != StG1);
      w_state_d = StIdle;
      w_last_d  = r_last;
      if (w_elig0 && w_elig1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
         w_state_d = StG0;
`else
         w_state_d = r_last ? StG0 : StG1;
`endif
      end else if (w_elig0) begin
         w_state_d = StG0;
      end else if (w_elig1) begin
         w_state_d = StG1;
      end
      if (w_state_d == StG0) begin
         w_last_d = 1'b0;
      end else if (w_state_d == StG1) begin
         w_last_d = 1'b1;
      end
   end

   always_comb begin
      o_ram_addr = i_addr0;
      o_ram_din  = i_wdata0;
      o_ram_we   = 1'b0;
      unique case (r_state)
         StG0: begin
            o_ram_we = i_we0;
         end
         StG1: begin
            o_ram_addr = i_addr1;
            o_ram_din  = i_wdata1;
            o_ram_we   = i_we1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= StIdle;
         r_last   <= 1'b1;
         r_ack0   <= 1'b0;
         r_ack1   <= 1'b0;
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else begin
         r_state <= w_state_d;
         r_last  <= w_last_d;
         r_ack0  <= (r_state == StG0);
         r_ack1  <= (r_state == StG1);
         if ((r_state == StG0) && !i_we0) begin
            r_rdata0 <= i_ram_dout;
         end
         if ((r_state == StG1) && !i_we1) begin
            r_rdata1 <= i_ram_dout;
         end
      end
   end

   assign o_gnt0   = (r_state == StG0);
   assign o_gnt1   = (r_state == StG1);
   assign o_ack0   = r_ack0;
   assign o_ack1   = r_ack1;
   assign o_rdata0 = r_rdata0;
   assign o_rdata1 = r_rdata1;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural combinational-read RAM.
module tb_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1, we0, we1;
   logic [7:0]  addr0, addr1;
   logic [15:0] wdata0, wdata1;
   logic        ack0, ack1, gnt0, gnt1, ram_we;
   logic [15:0] rdata0, rdata1, ram_din, ram_dout;
   logic [7:0]  ram_addr;

   logic [15:0] mem [256];
   logic [15:0] snap [256];
   logic        ld;
   logic [7:0]  ld_addr;
   logic [15:0] ld_data;
   int          errors = 0;
   int          checks = 0;
   logic        exp_g0, exp_g1, same;
   int          n_ack0, n_ack1;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else if (ld) mem[ld_addr] <= ld_data;
   end
   assign ram_dout = mem[ram_addr];

   ram_arbiter #(.WIDTH(16), .AW(8)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
      .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
      .o_ack0(ack0), .o_ack1(ack1), .o_rdata0(rdata0), .o_rdata1(rdata1),
      .o_gnt0(gnt0), .o_gnt1(gnt1),
      .o_ram_din(ram_din), .o_ram_addr(ram_addr), .o_ram_we(ram_we),
      .i_ram_dout(ram_dout)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   initial begin
      rst = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      ld = 0; ld_addr = 0; ld_data = 0;
      tick();
      ld = 1; ld_addr = 8'd5; ld_data = 16'h1234;
      tick();
      ld = 0;
      check("rst_ack0", ack0, 0);
      check("rst_ack1", ack1, 0);
      check("rst_rdata0", rdata0, 0);
      check("rst_rdata1", rdata1, 0);
      check("rst_gnt", {gnt0, gnt1}, 0);
      check("rst_we", ram_we, 0);
      rst = 0;

      // Single read of address 5 on port 0
      req0 = 1; we0 = 0; addr0 = 8'd5;
      check("rd_c0_gnt0", gnt0, 0);
      tick();
      check("rd_c1_gnt0", gnt0, 1);
      check("rd_c1_addr", ram_addr, 8'd5);
      check("rd_c1_we", ram_we, 0);
      check("rd_c1_ack0", ack0, 0);
      check("rd_c1_ack1", ack1, 0);
      tick();
      check("rd_c2_ack0", ack0, 1);
      check("rd_c2_rdata0", rdata0, 16'h1234);
      check("rd_c2_gnt0", gnt0, 0);
      check("rd_c2_ack1", ack1, 0);
      req0 = 0;
      tick();
      check("rd_c3_ack0", ack0, 0);
      check("rd_c3_hold", rdata0, 16'h1234);
      check("rd_c3_ack1", ack1, 0);

      // Port 1 writes BEEF to 3 then reads it back-to-back
      req1 = 1; we1 = 1; addr1 = 8'd3; wdata1 = 16'hBEEF;
      tick();
      check("wr_gnt1", gnt1, 1);
      check("wr_we", ram_we, 1);
      check("wr_addr", ram_addr, 8'd3);
      check("wr_din", ram_din, 16'hBEEF);
      tick();
      check("wr_ack1", ack1, 1);
      check("wr_rdata1", rdata1, 0);
      we1 = 0;
      tick();
      check("rb_gnt1", gnt1, 1);
      check("rb_ack1", ack1, 0);
      check("rb_we", ram_we, 0);
      tick();
      check("rb_ack1b", ack1, 1);
      check("rb_rdata1", rdata1, 16'hBEEF);
      req1 = 0;
      tick();

      // Contention from a fresh reset: G0 first, then strict alternation
      rst = 1;
      tick();
      rst = 0;
      req0 = 1; we0 = 0; addr0 = 8'd5;
      req1 = 1; we1 = 0; addr1 = 8'd3;
      tick();
      n_ack0 = 0; n_ack1 = 0;
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) begin
            exp_g0 = (i % 2 == 0);
            exp_g1 = (i % 2 == 1);
            check($sformatf("alt_gnt0_%0d", i), gnt0, exp_g0);
            check($sformatf("alt_gnt1_%0d", i), gnt1, exp_g1);
         end
         if (i > 0) begin
            n_ack0 += ack0;
            n_ack1 += ack1;
         end
         if (i == 8) req1 = 0;
         tick();
      end
      check("alt_nack0", n_ack0, 4);
      check("alt_nack1", n_ack1, 4);
      check("alt_last_ack0", ack0, 1);
      check("alt_rdata0", rdata0, 16'h1234);
      check("alt_rdata1", rdata1, 16'hBEEF);
      req0 = 0;
      tick();
      check("alt_idle", {gnt0, gnt1}, 0);

      // Lone port 0 access, back to idle, then a tie
      req0 = 1;
      tick();
      check("lone_gnt0", gnt0, 1);
      tick();
      check("lone_ack0", ack0, 1);
      req0 = 0;
      tick();
      check("lone_idle", {gnt0, gnt1}, 0);
      req0 = 1; req1 = 1;
      tick();
`ifdef RAM_ARB_FIXED_PRIO_EN
      check("tie_gnt0", gnt0, 1);
      check("tie_gnt1", gnt1, 0);
      tick();
      check("tie_second", gnt1, 1);
      req0 = 0;
      tick();
      req1 = 0;
`else
      check("tie_gnt0", gnt0, 0);
      check("tie_gnt1", gnt1, 1);
      tick();
      check("tie_second", gnt0, 1);
      req1 = 0;
      tick();
      req0 = 0;
`endif
      tick();
      check("tie_idle", {gnt0, gnt1}, 0);

      // Reset during a G1 read
      req1 = 1; we1 = 0; addr1 = 8'd3;
      tick();
      check("mid_gnt1", gnt1, 1);
      rst = 1;
      tick();
      check("mid_ack1", ack1, 0);
      check("mid_rdata1", rdata1, 0);
      check("mid_rdata0", rdata0, 0);
      check("mid_gnt", {gnt0, gnt1}, 0);
      check("mid_we", ram_we, 0);
      rst = 0; req1 = 0;
      tick();

      // Idle safety
      for (int a = 0; a < 256; a++) snap[a] = mem[a];
      for (int i = 0; i < 20; i++) begin
         tick();
         check($sformatf("idle_we_%0d", i), ram_we, 0);
         check($sformatf("idle_ack_%0d", i), {ack0, ack1}, 0);
      end
      same = 1'b1;
      for (int a = 0; a < 256; a++) if (mem[a] !== snap[a]) same = 1'b0;
      check("idle_mem_same", same, 1);
      check("idle_mem3", mem[3], 16'hBEEF);
      check("idle_mem5", mem[5], 16'h1234);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter that shares one single-port, combinational-read RAM between the core data path (port 0) and the loader/debug port (port 1). It owns the RAM's `din`, `addr` and `write_en` pins and returns read data through per-port registers with a one-cycle acknowledge pulse. The block sits between the core/loader and the RAM instance in the top level; a port issues a new request by holding its request and waiting for its acknowledge.

## Interface
- `WIDTH`, default 16, data width; must match the RAM.
- `AW`, default 8, address width; must match the RAM address port.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `req0` / `req1`  in  1  access request, held until the matching `ack`.
- `we0` / `we1`  in  1  1 = write, 0 = read; held with `req`.
- `addr0` / `addr1`  in  AW  access address; held with `req`.
- `wdata0` / `wdata1`  in  WIDTH  write data; held with `req`.
- `ack0` / `ack1`  out  1  one-cycle pulse, the cycle after the access.
- `rdata0` / `rdata1`  out  WIDTH  registered read data; valid when `ack` is high, held until the next read on that port.
- `gnt0` / `gnt1`  out  1  high during the cycle the port drives the RAM.
- `ram_din`  out  WIDTH  to RAM `din`.
- `ram_addr`  out  AW  to RAM `addr`.
- `ram_we`  out  1  to RAM `write_en`.
- `ram_dout`  in  WIDTH  from RAM `dout` (combinational read).

## Operation
- States: `IDLE`, `G0` (port 0 owns the RAM), `G1` (port 1 owns the RAM). `gnt0` = (state == `G0`) and `gnt1` = (state == `G1`), both decoded from the state register.
- RAM mux (combinational):
  - In `Gx`: `ram_addr` = `addrx`, `ram_din` = `wdatax`, `ram_we` = `wex`.
  - In `IDLE`: `ram_we` = 0, and `ram_addr` / `ram_din` = port 0 fields. This keeps the RAM from ever being written outside a grant.
- End of a `Gx` cycle:
  - `ackx` is set to 1 for exactly one cycle.
  - On a read, `rdatax` captures `ram_dout`.
  - On a write, `rdatax` is unchanged.
- Arbitration happens on every edge where the state is `IDLE` or `Gx`. The just-served port x is masked out for that edge, because its `req` is still high until it sees `ack`.
  - Only one eligible requester: it wins.
  - Both eligible: the winner is the port not granted most recently (round robin). A `last` pointer updates on every grant and resets to 1, so port 0 wins the first tie.
  - None eligible: next state is `IDLE`.
- During the `ack` cycle a port may keep `req` high with new fields to issue a back-to-back request; that request is eligible at the next edge.
- Requester contract: fields must be stable from `req` rise until `ack`. Dropping `req` before `ack` is illegal; the access still completes and `ack` still pulses.

## Timing
- Latency, idle arbiter: `req` high in cycle N → `gnt` in N+1 → `ack`/`rdata` valid in N+2.
- The write lands in the RAM at the end of the `gnt` cycle, so a read in the following grant returns the new value.
- Throughput:
  - A single port achieves at most 1 access per 2 cycles.
  - Two ports both requesting alternate `G0`, `G1`, `G0`, … giving 1 access per cycle, with no starvation.
- Reset (`rst` high at an edge, including mid-grant):
  - state → `IDLE`, `last` → 1;
  - `ack0` = `ack1` = 0;
  - `rdata0` = `rdata1` = 0.
  - A grant in progress when reset is sampled does not produce an `ack`. The RAM write for that cycle still occurs, because the RAM samples the same edge; this is accepted.
- Outputs in the first cycle after reset: `gnt*` = 0, `ram_we` = 0.

## Configuration
- `RAM_ARB_FIXED_PRIO_EN`:
  - Defined: on a tie in `IDLE`, port 0 always wins and `last` is ignored. The just-served masking still applies, so port 1 is served after every port 0 access when both request.
  - Undefined (default): round robin as described in Operation.

## Test plan
- Single read: reset, RAM[5] preloaded = 16'h1234. Assert `req0`, `we0` = 0, `addr0` = 5 at cycle 0 → `gnt0` in cycle 1, `ack0` = 1 and `rdata0` = 16'h1234 in cycle 2, `ack1` never high.
- Write then read: port 1 writes 16'hBEEF to address 3, then immediately re-requests a read of address 3 during its `ack` cycle → second `ack1` arrives 2 cycles after the first, with `rdata1` = 16'hBEEF.
- Contention: `req0` and `req1` both rise in the same cycle from `IDLE` after reset → order is `G0`, `G1`.
  - Both keep re-requesting: grants alternate every cycle for 8 cycles, 4 acks each.
  - With `RAM_ARB_FIXED_PRIO_EN` the first winner is also port 0.
- Round-robin tie: after a lone port 0 access and a return to `IDLE`, both request together → port 1 wins (default build); port 0 wins with `RAM_ARB_FIXED_PRIO_EN`.
- Reset mid-grant: assert `rst` during a `G1` read cycle → next cycle state `IDLE`, `ack1` = 0, `rdata1` = 0, `gnt*` = 0, `ram_we` = 0.
- Idle safety: no requests for 20 cycles → `ram_we` stays 0, RAM contents unchanged, no `ack` pulses.
